keccak_absorb: RTL and testbench
================================

# keccak_absorb

Upstream neighbour of the Keccak padding/finalize stage. Accepts a message as a byte stream, XORs each byte into the 1600-bit sponge state at the current byte position, and runs an external Keccak-f[1600] permutation every time `r` bytes have been absorbed. On end of message it presents the state and current byte position `pos` to the finalize stage, which applies padding at `pos` and at `r-1`.

## Interface
Parameters: none. Rate is a run-time input.

- `clock` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `r` in 32: rate in bytes (168 SHAKE128, 136 SHAKE256). Latched on IDLE exit; must be a multiple of 8, 8..200.
- `in_byte` in 8: message byte.
- `in_keep` in 1: 1 = `in_byte` carries data; 0 = control-only beat (legal only with `in_last`=1).
- `in_last` in 1: final beat of the message.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: block accepts a beat; a transfer occurs when `in_valid & in_ready`.
- `perm_start` out 1: one-cycle request to the permutation core.
- `perm_state_out` out 1600: state sent to the permutation; lane x at bits [64x+63:64x].
- `perm_done` in 1: permutation result valid, one cycle.
- `perm_state_in` in 1600: permuted state, same lane layout.
- `linear_s_out` out 1600: absorbed state to finalize, same lane layout.
- `pos` out 32: next free byte position, 0..r-1.
- `rts` out 1: `linear_s_out`/`pos` valid for downstream.
- `rtr` in 1: downstream ready to take the result.

## Operation
- State is 25 lanes `s[0..24]` of 64 bits. Byte position p maps to lane p/8, bits [8*(p%8)+7 : 8*(p%8)] (little-endian within a lane).
- FSM states: IDLE, ABSORB, PERM_REQ, PERM_WAIT, DONE.
- IDLE: clear all lanes to 0, `pos`=0, latch `r`, clear `last_seen`; go to ABSORB next cycle.
- ABSORB: `in_ready`=1. On a transfer with `in_keep`=1: `s[pos/8] ^= in_byte << 8*(pos%8)`, `pos`+1. If `in_last`=1, set `last_seen`.
  - New `pos` == r: go to PERM_REQ (regardless of `in_last`).
  - Else if `in_last`: go to DONE.
  - Transfer with `in_keep`=0, `in_last`=1: no state or `pos` change; go to DONE. `in_keep`=0 with `in_last`=0 is ignored (beat consumed, no effect).
- PERM_REQ: `perm_start`=1 for exactly this cycle; `perm_state_out` = current state (driven continuously from `s` in all states). Next: PERM_WAIT.
- PERM_WAIT: wait for `perm_done`; on it, load `s` from `perm_state_in`, `pos`=0; go to DONE if `last_seen`, else ABSORB. `perm_done` outside PERM_WAIT is ignored.
- DONE: `rts`=1, state and `pos` frozen. When `rtr`=1, the transfer completes; next state IDLE (next message starts from zero state).
- A message whose length is an exact multiple of r ends with `pos`=0 after the final permutation; finalize pads at byte 0.

## Timing
- Reset values: FSM=IDLE, all lanes 0, `pos`=0, `in_ready`=0, `perm_start`=0, `rts`=0, `last_seen`=0.
- Reset asserted in any state (including PERM_WAIT) aborts; a later stray `perm_done` is ignored.
- Throughput 1 byte/cycle in ABSORB; `in_ready` is 0 in all other states.
- Byte accepted at cycle t is visible in `linear_s_out` at t+1.
- Rate block: last byte at t, `perm_start` at t+1, earliest `perm_done` at t+2, `in_ready` again at the cycle after `perm_done`.
- End of message (no permutation): last beat at t, `rts`=1 from t+1 until the cycle `rtr`=1 is sampled; `rts`=0 the cycle after.
- `rtr` high before DONE has no effect. `pos` width 32, never exceeds r-1 when observed in DONE.

## Test plan
- r=168; bytes 0x01,0x02,0x03 (last on 0x03) -> `rts`=1, lane0 = 0x0000000000030201, other lanes 0, `pos`=3, no `perm_start`.
- r=168; 168 bytes 0xFF, last on byte 168 -> one `perm_start` pulse; model returns lane k = k after 5 cycles -> DONE with `linear_s_out` = returned state, `pos`=0.
- r=136; 138 bytes i&0xFF -> one permutation after byte 136, then lane0 of the post-permutation state XOR 0x8988 (bytes 136,137 = 0x88,0x89), `pos`=2.
- Empty message: single beat `in_keep`=0, `in_last`=1 -> `rts` next cycle, all lanes 0, `pos`=0.
- Backpressure: hold `rtr`=0 for 10 cycles in DONE -> `rts`, `linear_s_out`, `pos` stable, `in_ready`=0; `rtr`=1 -> IDLE, then lanes cleared and `in_ready`=1 two cycles later.
- `reset` during PERM_WAIT, then `perm_done` pulsed -> all lanes 0, `pos`=0, `rts`=0, FSM proceeds IDLE->ABSORB with `perm_done` ignored.

Source files
------------

// File: rtl/keccak_absorb.sv
// keccak_absorb: byte-serial absorb of a message into the 1600-bit Keccak sponge state.
// Requests an external Keccak-f[1600] every r bytes and hands state/pos to finalize at end of message.
module keccak_absorb (
   input  logic          clock,
   input  logic          reset,
   input  logic [31:0]   r,
   input  logic [7:0]    in_byte,
   input  logic          in_keep,
   input  logic          in_last,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          perm_start,
   output logic [1599:0] perm_state_out,
   input  logic          perm_done,
   input  logic [1599:0] perm_state_in,
   output logic [1599:0] linear_s_out,
   output logic [31:0]   pos,
   output logic          rts,
   input  logic          rtr
);

   typedef enum logic [2:0] {
      IDLE,
      ABSORB,
      PERM_REQ,
      PERM_WAIT,
      DONE
   } state_t;

   localparam int unsigned STATE_BYTES = 200;

   state_t        state, state_next;
   logic [1599:0] s, s_next;
   logic [31:0]   pos_next;
   logic [31:0]   pos_inc;
   logic [31:0]   rate, rate_next;
   logic          last_seen, last_next;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         s         <= '0;
         pos       <= '0;
         rate      <= '0;
         last_seen <= 1'b0;
      end else begin
         state     <= state_next;
         s         <= s_next;
         pos       <= pos_next;
         rate      <= rate_next;
         last_seen <= last_next;
      end
   end

   assign pos_inc = pos + 32'd1;

   always_comb begin
      state_next = state;
      s_next     = s;
      pos_next   = pos;
      rate_next  = rate;
      last_next  = last_seen;
      in_ready   = 1'b0;
      perm_start = 1'b0;
      rts        = 1'b0;

      unique case (state)
         IDLE: begin
            s_next     = '0;
            pos_next   = '0;
            rate_next  = r;
            last_next  = 1'b0;
            state_next = ABSORB;
         end

         ABSORB: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_keep) begin
                  // byte p lands in lane p/8 at bit offset 8*(p%8), i.e. flat byte p of s
                  for (int unsigned b = 0; b < STATE_BYTES; b++) begin
                     if (pos == 32'(b)) begin
                        s_next[8*b +: 8] = s[8*b +: 8] ^ in_byte;
                     end
                  end
                  pos_next = pos_inc;
                  if (in_last) begin
                     last_next = 1'b1;
                  end
                  if (pos_inc == rate) begin
                     state_next = PERM_REQ;
                  end else if (in_last) begin
                     state_next = DONE;
                  end
               end else if (in_last) begin
                  last_next  = 1'b1;
                  state_next = DONE;
               end
            end
         end

         PERM_REQ: begin
            perm_start = 1'b1;
            state_next = PERM_WAIT;
         end

         PERM_WAIT: begin
            if (perm_done) begin
               s_next     = perm_state_in;
               pos_next   = '0;
               state_next = last_seen ? DONE : ABSORB;
            end
         end

         DONE: begin
            rts = 1'b1;
            if (rtr) begin
               state_next = IDLE;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign perm_state_out = s;
   assign linear_s_out   = s;

endmodule

// File: tb/tb_keccak_absorb.sv
// Self-checking bench for keccak_absorb: byte-array sponge model, scoreboard queues,
// a behavioural permutation responder and a decoupled output monitor.
module tb_keccak_absorb;

   logic          clock = 1'b0;
   logic          reset;
   logic [31:0]   r;
   logic [7:0]    in_byte;
   logic          in_keep;
   logic          in_last;
   logic          in_valid;
   logic          in_ready;
   logic          perm_start;
   logic [1599:0] perm_state_out;
   logic          perm_done;
   logic [1599:0] perm_state_in;
   logic [1599:0] linear_s_out;
   logic [31:0]   pos;
   logic          rts;
   logic          rtr;

   keccak_absorb dut (
      .clock          (clock),
      .reset          (reset),
      .r              (r),
      .in_byte        (in_byte),
      .in_keep        (in_keep),
      .in_last        (in_last),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .perm_start     (perm_start),
      .perm_state_out (perm_state_out),
      .perm_done      (perm_done),
      .perm_state_in  (perm_state_in),
      .linear_s_out   (linear_s_out),
      .pos            (pos),
      .rts            (rts),
      .rtr            (rtr)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1599:0] st;
      logic [31:0]   p;
   } res_t;

   int unsigned   tests = 0;
   int unsigned   fails = 0;
   res_t          exp_q[$];
   logic [1599:0] perm_q[$];
   logic [7:0]    msg_q[$];
   logic [7:0]    mb[200];

   bit perm_const = 1'b0;
   bit hold_resp  = 1'b0;
   bit stray_req  = 1'b0;
   bit gaps       = 1'b1;
   bit bubbles    = 1'b1;
   int rtr_mode   = 0;
   int fixed_lat  = -1;

   // ---------------- reference model helpers ----------------
   function automatic logic [1599:0] pack_model();
      logic [1599:0] v;
      for (int i = 0; i < 200; i++) v[8*i +: 8] = mb[i];
      return v;
   endfunction

   function automatic void unpack_model(input logic [1599:0] v);
      for (int i = 0; i < 200; i++) mb[i] = v[8*i +: 8];
   endfunction

   // stand-in permutation: any fixed bijection-ish mixing suffices to test plumbing
   function automatic logic [1599:0] perm_fn(input logic [1599:0] st);
      logic [1599:0] o;
      logic [63:0]   ln;
      for (int k = 0; k < 25; k++) begin
         ln = st[64*k +: 64];
         if (perm_const) o[64*k +: 64] = 64'(k);
         else            o[64*k +: 64] = {ln[62:0], ln[63]} ^ (64'(k + 1) * 64'h9E3779B97F4A7C15);
      end
      return o;
   endfunction

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chkst(input string nm, input logic [1599:0] act, input logic [1599:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         for (int k = 0; k < 25; k++) begin
            if (act[64*k +: 64] !== exp[64*k +: 64]) begin
               $display("FAIL %s lane %0d: got %h expected %h", nm, k, act[64*k +: 64], exp[64*k +: 64]);
               break;
            end
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic send_beat(input logic [7:0] b, input bit keep, input bit last);
      int unsigned n = 0;
      while (gaps && $urandom_range(0, 3) == 0) begin
         in_valid = 1'b0;
         in_byte  = 8'($urandom);
         @(posedge clock); #1;
      end
      in_valid = 1'b1;
      in_byte  = b;
      in_keep  = keep;
      in_last  = last;
      do begin
         @(negedge clock);
         n++;
      end while (!in_ready && n < 400);
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL in_ready timeout: got 0 expected 1 within 400 cycles");
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      in_keep  = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_msg(input int unsigned rate, input bit trail, input bit push_res);
      int unsigned   p = 0;
      bit            last;
      res_t          e;
      logic [1599:0] v;
      for (int i = 0; i < 200; i++) mb[i] = 8'h00;
      r = rate;
      for (int unsigned i = 0; i < msg_q.size(); i++) begin
         last = !trail && (i == msg_q.size() - 1);
         if (bubbles && $urandom_range(0, 7) == 0) send_beat(8'($urandom), 1'b0, 1'b0);
         mb[p] = mb[p] ^ msg_q[i];
         p++;
         if (p == rate) begin
            v = pack_model();
            perm_q.push_back(v);
            unpack_model(perm_fn(v));
            p = 0;
         end
         if (last && push_res) begin
            e.st = pack_model();
            e.p  = p;
            exp_q.push_back(e);
         end
         send_beat(msg_q[i], 1'b1, last);
      end
      if (trail || msg_q.size() == 0) begin
         if (push_res) begin
            e.st = pack_model();
            e.p  = p;
            exp_q.push_back(e);
         end
         send_beat(8'($urandom), 1'b0, 1'b1);
      end
   endtask

   task automatic wait_drain();
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clock);
         n++;
      end
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain timeout: %0d results outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- downstream ready driver ----------------
   initial begin
      rtr = 1'b0;
      forever begin
         @(posedge clock); #1;
         case (rtr_mode)
            0:       rtr = ($urandom_range(0, 2) == 0);
            1:       rtr = 1'b0;
            default: rtr = 1'b1;
         endcase
      end
   end

   // ---------------- permutation responder ----------------
   initial begin
      bit            pending = 1'b0;
      logic [1599:0] pend_st = '0;
      int            wait_cnt = 0;
      perm_done     = 1'b0;
      perm_state_in = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            pending = 1'b0;
         end else if (perm_start) begin
            pending  = 1'b1;
            pend_st  = perm_state_out;
            wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
         end
         @(posedge clock); #1;
         perm_done = 1'b0;
         if (stray_req) begin
            perm_done = 1'b1;
            for (int k = 0; k < 50; k++) perm_state_in[32*k +: 32] = $urandom;
            stray_req = 1'b0;
         end else if (pending && !hold_resp) begin
            if (wait_cnt == 0) begin
               perm_done     = 1'b1;
               perm_state_in = perm_fn(pend_st);
               pending       = 1'b0;
            end else begin
               wait_cnt--;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      res_t e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (perm_start) begin
               if (perm_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL perm_start: got unexpected pulse, expected none");
               end else begin
                  chkst("perm_state_out", perm_state_out, perm_q.pop_front());
               end
               chk32("in_ready_during_perm_req", 32'(in_ready), 32'd0);
            end
            if (rts && rtr) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL rts: got unexpected result, expected none");
               end else begin
                  e = exp_q.pop_front();
                  chkst("linear_s_out", linear_s_out, e.st);
                  chk32("pos", pos, e.p);
                  chk32("in_ready_in_done", 32'(in_ready), 32'd0);
               end
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [1599:0] snap_s;
      logic [31:0]   snap_p;
      int unsigned   n;
      int unsigned   rate;
      int unsigned   len;

      reset    = 1'b1;
      r        = 32'd168;
      in_valid = 1'b0;
      in_byte  = '0;
      in_keep  = 1'b0;
      in_last  = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk32("reset_in_ready", 32'(in_ready), 32'd0);
      chk32("reset_perm_start", 32'(perm_start), 32'd0);
      chk32("reset_rts", 32'(rts), 32'd0);
      chk32("reset_pos", pos, 32'd0);
      chkst("reset_lanes", linear_s_out, '0);
      @(posedge clock); #1;
      reset = 1'b0;

      // three bytes, r=168
      msg_q = '{8'h01, 8'h02, 8'h03};
      send_msg(168, 1'b0, 1'b1);
      wait_drain();

      // exactly one rate block of 0xFF, constant permutation, ends at pos 0
      perm_const = 1'b1;
      fixed_lat  = 4;
      msg_q.delete();
      for (int i = 0; i < 168; i++) msg_q.push_back(8'hFF);
      send_msg(168, 1'b0, 1'b1);
      wait_drain();
      perm_const = 1'b0;
      fixed_lat  = -1;

      // r=136, 138 bytes of i&0xFF
      msg_q.delete();
      for (int i = 0; i < 138; i++) msg_q.push_back(8'(i));
      send_msg(136, 1'b0, 1'b1);
      wait_drain();

      // empty message
      msg_q.delete();
      send_msg(136, 1'b1, 1'b1);
      wait_drain();

      // randomized messages, including exact multiples of r and trailing control beats
      for (int m = 0; m < 24; m++) begin
         rate = 8 * $urandom_range(1, 25);
         if (m % 4 == 0) len = rate * $urandom_range(1, 2);
         else            len = $urandom_range(0, 2 * rate + 3);
         msg_q.delete();
         for (int unsigned i = 0; i < len; i++) msg_q.push_back(8'($urandom));
         send_msg(rate, (len == 0) || ($urandom_range(0, 3) == 0), 1'b1);
         wait_drain();
      end

      // backpressure in DONE
      rtr_mode = 1;
      msg_q.delete();
      for (int i = 0; i < 5; i++) msg_q.push_back(8'($urandom));
      send_msg(136, 1'b0, 1'b1);
      n = 0;
      while (!rts && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk32("bp_rts_reached", 32'(rts), 32'd1);
      snap_s = linear_s_out;
      snap_p = pos;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         chk32("bp_rts_held", 32'(rts), 32'd1);
         chk32("bp_in_ready_low", 32'(in_ready), 32'd0);
         chkst("bp_state_stable", linear_s_out, snap_s);
         chk32("bp_pos_stable", pos, snap_p);
      end
      rtr_mode = 2;
      @(negedge clock);
      @(negedge clock);
      chk32("bp_idle_rts", 32'(rts), 32'd0);
      chk32("bp_idle_in_ready", 32'(in_ready), 32'd0);
      @(negedge clock);
      chk32("bp_absorb_in_ready", 32'(in_ready), 32'd1);
      chkst("bp_absorb_lanes", linear_s_out, '0);
      chk32("bp_absorb_pos", pos, 32'd0);
      rtr_mode = 0;
      wait_drain();

      // reset while waiting for the permutation, then a stray perm_done
      r = 32'd8;
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset     = 1'b0;
      hold_resp = 1'b1;
      msg_q.delete();
      for (int i = 0; i < 8; i++) msg_q.push_back(8'($urandom));
      send_msg(8, 1'b0, 1'b0);
      n = 0;
      while (perm_q.size() != 0 && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk32("rst_perm_start_seen", perm_q.size(), 32'd0);
      @(negedge clock);
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk32("rst_idle_rts", 32'(rts), 32'd0);
      chk32("rst_idle_pos", pos, 32'd0);
      chkst("rst_idle_lanes", linear_s_out, '0);
      stray_req = 1'b1;
      hold_resp = 1'b0;
      @(negedge clock);
      chk32("rst_absorb_in_ready", 32'(in_ready), 32'd1);
      chk32("rst_stray_done_seen", 32'(perm_done), 32'd1);
      @(negedge clock);
      chkst("rst_stray_lanes", linear_s_out, '0);
      chk32("rst_stray_pos", pos, 32'd0);
      chk32("rst_stray_rts", 32'(rts), 32'd0);
      chk32("rst_stray_in_ready", 32'(in_ready), 32'd1);

      // fresh message after abort starts from the zero state
      msg_q.delete();
      for (int i = 0; i < 11; i++) msg_q.push_back(8'($urandom));
      send_msg(8, 1'b0, 1'b1);
      wait_drain();

      repeat (5) @(negedge clock);
      chk32("exp_q_empty", exp_q.size(), 32'd0);
      chk32("perm_q_empty", perm_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
